bit_serial_adder: RTL
=====================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand and sum width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a, b (and sub) are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port sub, input, 1 bit, present only when SUB_EN is defined: 1 selects A-B, 0 selects A+B.
REQ-009 SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement three states: IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both decoded from registered state.
REQ-016 SHALL, on an edge with in_valid && in_ready, latch a, b and sub, clear the bit counter, load carry=sub (0 without SUB_EN), and go to RUN.
REQ-017 SHALL ignore a, b, sub and in_valid while not in IDLE; in_valid without in_ready SHALL have no effect.
REQ-018 SHALL, in RUN, process one bit per cycle LSB first: s=A[i]^B'[i]^c, c=majority(A[i],B'[i],c), where B'=b when sub=0 and B'=~b when sub=1.
REQ-019 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, so out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-020 SHALL hold sum and cout stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-021 SHALL accept new operands no earlier than the cycle after the result handshake; throughput is one operation per WIDTH+2 cycles with out_ready held high.
REQ-022 SHALL never use out_ready outside DONE.
REQ-023 SHALL, when sub=1, set cout=1 when A>=B and cout=0 on borrow.

Reset
REQ-024 SHALL, while rst=1, immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal carry=0 and counter=0, with no clock edge required.
REQ-025 SHALL, on reset in RUN or DONE, abandon the operation and produce no result for it.
REQ-026 SHALL accept operands on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL include the sub port and subtract datapath only when the macro BIT_SERIAL_ADDER_SUB_EN is defined.
REQ-028 SHALL, without BIT_SERIAL_ADDER_SUB_EN, have no sub port and perform addition only, with carry-in 0.

Verification (WIDTH=4)
REQ-029 SHALL cover this addition case: a=9, b=6 -> out_valid 4 cycles after accept; sum=15, cout=0.
REQ-030 SHALL cover this wrap-around case: a=15, b=1 -> sum=0, cout=1; then a=0, b=0 -> sum=0, cout=0.
REQ-031 SHALL cover this backpressure case: out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid held; in_ready=0 throughout; in_valid pulsed with a=3 is ignored.
REQ-032 SHALL cover this reset case: assert rst 2 cycles after accepting a=7, b=7 -> outputs go to reset values immediately; no out_valid appears; next operation a=2, b=3 gives sum=5.
REQ-033 SHALL cover these subtract cases, with BIT_SERIAL_ADDER_SUB_EN defined: a=5, b=7, sub=1 -> sum=14, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-034 SHALL cover an exhaustive check: all 256 a/b pairs back-to-back with out_ready=1 -> each {cout,sum}=a+b, with interval WIDTH+2 cycles.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// +--------------------------------------------------------------------------+
// | Module      : bit_serial_adder_if                                        |
// | Description : Operand/result handshake bundle for bit_serial_adder.      |
// |               Operand side: in_valid/in_ready with a, b (and sub).       |
// |               Result side : out_valid/out_ready with sum, cout.          |
// |               The sub signal exists only when BIT_SERIAL_ADDER_SUB_EN    |
// |               is defined.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bit_serial_adder_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/bit_serial_adder.sv
// +--------------------------------------------------------------------------+
// | Module      : bit_serial_adder                                           |
// | Description : Bit-serial ripple adder. Operands are accepted in IDLE,    |
// |               one bit per clock is processed LSB-first in RUN, and the   |
// |               WIDTH-bit sum plus carry-out are held in DONE until the    |
// |               consumer takes them.                                       |
// |               Optional feature macro: BIT_SERIAL_ADDER_SUB_EN adds the   |
// |               sub input and the A-B datapath (B inverted, carry-in 1).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module bit_serial_adder #(
  parameter int WIDTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bit_serial_adder_if.slave bus
);

  // Counter only needs to index bits 0..WIDTH-1.
  localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  generate
    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
      $error("bit_serial_adder: WIDTH must be in the range 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // Operand shift registers: bit 0 is always the bit being processed.
  // b_q holds the effective operand B' (already inverted for subtraction).
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  // Result shift register: each new bit enters at the MSB, so after WIDTH
  // shifts the first-computed bit has arrived at bit 0.
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             w_accept;
  logic             w_sub_in;
  logic             w_bit_sum;
  logic             w_bit_carry;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  // Subtract select: real input only when the feature is built in.
`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign w_sub_in = bus.sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // One full-adder slice operating on the current LSBs.
  assign w_bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // Operands are taken only from IDLE; in_valid is ignored elsewhere.
  assign w_accept = (state_q == IDLE) && bus.in_valid;

  // Next-state and handshake decode from the registered state.
  always_comb begin
    state_d     = state_q;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (state_q)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        // out_ready is only looked at here.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle,
  // otherwise hold (keeps sum/cout stable through DONE).
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      a_d     = bus.a;
      b_d     = bus.b ^ {WIDTH{w_sub_in}};
      carry_d = w_sub_in;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = {w_bit_sum, sum_q[WIDTH-1:1]};
      carry_d = w_bit_carry;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = sum_q;
  // After the last bit the running carry is the carry out of bit WIDTH-1.
  assign bus.cout      = carry_q;

endmodule

`default_nettype wire
